// File: rtl/program_loader.sv
// Boot loader: big-endian byte stream -> inst/data memory words, then ACK/NAK byte and done/error.
// Write strobe lands 1 cycle after a word's 4th byte; rx stalls outside LEN/BODY, tx holds until taken.
module program_loader #(
  parameter int         INST_DEPTH = 200,
  parameter int         DATA_DEPTH = 200,
  parameter int         ADDR_W     = 16,
  parameter logic [7:0] ACK_BYTE   = 8'hAA,
  parameter logic [7:0] NAK_BYTE   = 8'h55
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              inst_we,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_wdata,
  output logic              data_we,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    INST_LEN, INST_BODY, DATA_LEN, DATA_BODY, ACK, DONE, NAK, ERR
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [31:0]       len;
  logic [23:0]       word;
  logic [ADDR_W-1:0] word_cnt;
  logic [31:0]       len_full, word_full;
  logic              last_in, word_last, rx_fire;

  assign len_full  = {len[23:0], rx_data};
  assign word_full = {word, rx_data};
  // rx_valid rather than the handshake: rx_ready is produced below and is 1 in every state that reads this
  assign last_in   = rx_valid && (byte_cnt == 2'd3);
  assign word_last = (32'(word_cnt) + 32'd1) == len;
  assign rx_fire   = rx_valid && rx_ready;

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    done      = 1'b0;
    error     = 1'b0;
    if (!RST) begin
      case (state)
        INST_LEN: begin
          rx_ready = 1'b1;
          if (last_in) begin
            if (len_full > 32'(INST_DEPTH)) state_nxt = NAK;
            else if (len_full == 32'd0)     state_nxt = DATA_LEN;
            else                            state_nxt = INST_BODY;
          end
        end
        INST_BODY: begin
          rx_ready = 1'b1;
          if (last_in && word_last) state_nxt = DATA_LEN;
        end
        DATA_LEN: begin
          rx_ready = 1'b1;
          if (last_in) begin
            if (len_full > 32'(DATA_DEPTH)) state_nxt = NAK;
            else if (len_full == 32'd0)     state_nxt = ACK;
            else                            state_nxt = DATA_BODY;
          end
        end
        DATA_BODY: begin
          rx_ready = 1'b1;
          if (last_in && word_last) state_nxt = ACK;
        end
        ACK: begin
          tx_valid = 1'b1;
          tx_data  = ACK_BYTE;
          if (tx_ready) state_nxt = DONE;
        end
        NAK: begin
          tx_valid = 1'b1;
          tx_data  = NAK_BYTE;
          if (tx_ready) state_nxt = ERR;
        end
        DONE:    done  = 1'b1;
        ERR:     error = 1'b1;
        default: state_nxt = INST_LEN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= INST_LEN;
      byte_cnt   <= 2'd0;
      word_cnt   <= '0;
      len        <= 32'd0;
      word       <= 24'd0;
      inst_we    <= 1'b0;
      inst_addr  <= '0;
      inst_wdata <= 32'd0;
      data_we    <= 1'b0;
      data_addr  <= '0;
      data_wdata <= 32'd0;
    end else begin
      state   <= state_nxt;
      inst_we <= 1'b0;
      data_we <= 1'b0;
      if (rx_fire) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == INST_LEN || state == DATA_LEN) len <= len_full;
        else                                        word <= word_full[23:0];
        if (byte_cnt == 2'd3 && state == INST_BODY) begin
          inst_we    <= 1'b1;
          inst_addr  <= word_cnt;
          inst_wdata <= word_full;
          word_cnt   <= word_cnt + ADDR_W'(1);
        end
        if (byte_cnt == 2'd3 && state == DATA_BODY) begin
          data_we    <= 1'b1;
          data_addr  <= word_cnt;
          data_wdata <= word_full;
          word_cnt   <= word_cnt + ADDR_W'(1);
        end
      end
      // every state entry starts from a clean byte and word count
      if (state_nxt != state) begin
        byte_cnt <= 2'd0;
        word_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream stage of the core: at power-up, receives a program image as a byte stream from the UART receive side.
- Assembles the bytes into 32-bit words and writes them into instruction memory and data memory.
- When the image is complete, sends a one-byte acknowledge and asserts done. done releases the core from INIT, replacing the manual SW_W start.
- Image format, all big-endian: 4-byte instruction word count N, then N instruction words, then 4-byte data word count M, then M data words.

Parameters:
- INST_DEPTH, 200, instruction memory depth in words; N > INST_DEPTH is an error.
- DATA_DEPTH, 200, data memory depth in words; M > DATA_DEPTH is an error.
- ADDR_W, 16, width of inst_addr and data_addr.
- ACK_BYTE, 8'hAA, byte sent on successful load.
- NAK_BYTE, 8'h55, byte sent on error.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready at the CLK edge.
- tx_data  out  8  acknowledge byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts; a transfer occurs when tx_valid && tx_ready.
- inst_we  out  1  instruction memory write strobe.
- inst_addr  out  ADDR_W  instruction word address.
- inst_wdata  out  32  instruction word.
- data_we  out  1  data memory write strobe.
- data_addr  out  ADDR_W  data word address.
- data_wdata  out  32  data word.
- done  out  1  load complete; core may run.
- error  out  1  load aborted.

Behaviour:
Interface:
- One clock, CLK. Reset RST is synchronous and active-high. All state updates on posedge CLK.

Reset values:
- rx_ready=0, tx_valid=0, tx_data=0, inst_we=0, data_we=0, inst_addr=0, data_addr=0, inst_wdata=0, data_wdata=0, done=0, error=0.
- State=INST_LEN; byte counter=0; word counter=0.
- RST asserted in any state, including mid-word or mid-ack, aborts the load. No further writes or tx bytes are issued after that edge. The loader restarts at INST_LEN.

States:
- INST_LEN:
  - rx_ready=1. Shift 4 bytes into len, MSB first.
  - After the 4th byte: len > INST_DEPTH goes to NAK; len==0 goes to DATA_LEN; otherwise go to INST_BODY with word counter=0.
- INST_BODY:
  - rx_ready=1. Shift bytes into the word register.
  - On the 4th byte's handshake edge, register inst_wdata=word and inst_addr=word counter, and pulse inst_we=1 for exactly the next cycle.
  - Increment the word counter. When it reaches N, go to DATA_LEN.
- DATA_LEN: same as INST_LEN, using DATA_DEPTH and going to DATA_BODY. M==0 goes directly to ACK.
- DATA_BODY: same as INST_BODY, driving the data_* outputs. After M words, go to ACK.
- ACK:
  - rx_ready=0. tx_valid=1, tx_data=ACK_BYTE.
  - Hold both until the tx handshake, then go to DONE.
- DONE: done=1, rx_ready=0. Incoming bytes are ignored. Held until RST.
- NAK:
  - rx_ready=0. tx_valid=1, tx_data=NAK_BYTE.
  - On the handshake, go to ERR.
- ERR: error=1, rx_ready=0. Held until RST. No memory writes ever occur after an error is detected.

Rules:
- Write latency: the strobe appears one cycle after the final byte's handshake. The strobe for the last word of a section coincides with the first cycle of the next state.
- Addresses run 0..N-1 and 0..M-1 with no wrap; the depth check guarantees this.
- Boundary: N==INST_DEPTH is legal; N==INST_DEPTH+1 is an error. The same holds for M against DATA_DEPTH.
- The byte counter resets to 0 at every state entry, so a partial word never carries over.
- rx_valid gaps of any length between bytes are tolerated. No timeout.
- done and error are mutually exclusive and never both 1.

Test Plan:
- Nominal load:
  - Stimulus: N=2 words 0x20010005, 0x08000000; M=1 word 0x0000000A.
  - Required: inst_we pulses at addr 0 then 1 with those values; data_we pulses once at addr 0 with 0x0000000A.
  - Then tx_data=0xAA handshakes and done=1.
- Empty sections: N=0, M=0 (8 bytes of zero) → no write strobes; ACK 0xAA is sent; done=1.
- Depth boundary:
  - N=200 followed by 200 words → all 200 written, last at inst_addr=199.
  - N=201 → NAK 0x55 is sent, error=1, and zero inst_we pulses occur.
- Back-pressure and gaps:
  - rx_valid toggled randomly during the body → every word is assembled correctly.
  - tx_ready held 0 for 10 cycles in ACK → tx_valid and tx_data are stable throughout; done rises only after the handshake.
- Reset mid-operation: RST pulsed after 2 bytes of the 2nd instruction word → no further strobes. A subsequent full image loads correctly from address 0.
- After DONE: bytes 0x11, 0x22 with rx_valid=1 → rx_ready stays 0; no writes occur; done stays 1.
